// File: rtl/periodic_tx_sched.sv
// Periodic transmit scheduler: turns each timer tick into one ARP or UDP
// transmit request with start/done handshake, watchdog and drop statistics.
module periodic_tx_sched #(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned SEQ_W       = 16
) (
    input  logic             tx_clk,
    input  logic             rst_n,
    input  logic             timer_pulse,
    input  logic             enable,
    input  logic             arp_valid,
    output logic             arp_req,
    input  logic             arp_tx_done,
    output logic             udp_req,
    output logic [SEQ_W-1:0] udp_seq,
    input  logic             udp_tx_done,
    output logic             busy,
    input  logic             clr_stats,
    output logic [7:0]       drop_cnt,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARP_REQ  = 3'd1,
        ARP_WAIT = 3'd2,
        UDP_REQ  = 3'd3,
        UDP_WAIT = 3'd4
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] wd_cnt;
    logic        wd_hit;
    logic        tick_drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wd_hit    = (wd_cnt == WD_LAST);
    assign tick_drop = timer_pulse && (state != IDLE);

    // Request strobes and timeout_err default low so each is a single-cycle pulse.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            arp_req     <= 1'b0;
            udp_req     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            udp_seq     <= '0;
            wd_cnt      <= '0;
        end else begin
            arp_req     <= 1'b0;
            udp_req     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (timer_pulse && enable) begin
                        busy <= 1'b1;
                        if (arp_valid) begin
                            state   <= UDP_REQ;
                            udp_req <= 1'b1;
                        end else begin
                            state   <= ARP_REQ;
                            arp_req <= 1'b1;
                        end
                    end
                end
                ARP_REQ: begin
                    state  <= ARP_WAIT;
                    wd_cnt <= '0;
                end
                UDP_REQ: begin
                    state  <= UDP_WAIT;
                    wd_cnt <= '0;
                end
                ARP_WAIT: begin
                    if (arp_tx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wd_hit) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                UDP_WAIT: begin
                    // A done strobe on the threshold cycle still counts as success.
                    if (udp_tx_done) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        udp_seq <= udp_seq + SEQ_W'(1);
                    end else if (wd_hit) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Ticks arriving outside IDLE (including the done cycle) are dropped and counted.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (clr_stats) begin
            drop_cnt <= '0;
        end else if (tick_drop) begin
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

endmodule

// File: tb/tb_periodic_tx_sched.sv
// Directed testbench for periodic_tx_sched: a default-parameter instance and a
// short-timeout, 2-bit-sequence instance share the same stimulus.
module tb_periodic_tx_sched;

    logic        tx_clk = 1'b0;
    logic        rst_n, timer_pulse, enable, arp_valid;
    logic        arp_tx_done, udp_tx_done, clr_stats;

    logic        arp_req, udp_req, busy, timeout_err;
    logic [15:0] udp_seq;
    logic [7:0]  drop_cnt;

    logic        arp_req_s, udp_req_s, busy_s, timeout_err_s;
    logic [1:0]  udp_seq_s;
    logic [7:0]  drop_cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 tx_clk = ~tx_clk;

    periodic_tx_sched u_main (
        .tx_clk(tx_clk), .rst_n(rst_n), .timer_pulse(timer_pulse), .enable(enable),
        .arp_valid(arp_valid), .arp_req(arp_req), .arp_tx_done(arp_tx_done),
        .udp_req(udp_req), .udp_seq(udp_seq), .udp_tx_done(udp_tx_done),
        .busy(busy), .clr_stats(clr_stats), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
    );

    periodic_tx_sched #(.TIMEOUT_CYC(16), .SEQ_W(2)) u_short (
        .tx_clk(tx_clk), .rst_n(rst_n), .timer_pulse(timer_pulse), .enable(enable),
        .arp_valid(arp_valid), .arp_req(arp_req_s), .arp_tx_done(arp_tx_done),
        .udp_req(udp_req_s), .udp_seq(udp_seq_s), .udp_tx_done(udp_tx_done),
        .busy(busy_s), .clr_stats(clr_stats), .drop_cnt(drop_cnt_s), .timeout_err(timeout_err_s)
    );

    task automatic step();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; timer_pulse = 1'b0; enable = 1'b1; arp_valid = 1'b0;
        arp_tx_done = 1'b0; udp_tx_done = 1'b0; clr_stats = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; timer_pulse = 1'b0; enable = 1'b0; arp_valid = 1'b0;
        arp_tx_done = 1'b0; udp_tx_done = 1'b0; clr_stats = 1'b0;
        step();
        total++;
        if ({arp_req, udp_req, busy, timeout_err, udp_seq, drop_cnt} !== 28'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h want=0", {arp_req, udp_req, busy, timeout_err, udp_seq, drop_cnt});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_arp();
        apply_reset();
        arp_valid = 1'b0; enable = 1'b1;
        repeat (3) step();
        timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
        total++;
        if ({arp_req, udp_req, busy} !== 3'b101) begin
            bad++; $display("FAIL arp_req_start got=%b want=101", {arp_req, udp_req, busy});
        end
        enable = 1'b0;
        step();
        total++;
        if ({arp_req, busy} !== 2'b01) begin
            bad++; $display("FAIL arp_req_single got=%b want=01", {arp_req, busy});
        end
        udp_tx_done = 1'b1; step(); udp_tx_done = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL arp_ignore_udp_done busy got=%b want=1", busy);
        end
        repeat (6) step();
        arp_tx_done = 1'b1; step(); arp_tx_done = 1'b0;
        total++;
        if (busy !== 1'b0 || udp_seq !== 16'd0) begin
            bad++; $display("FAIL arp_done got busy=%b seq=%0d want busy=0 seq=0", busy, udp_seq);
        end
        enable = 1'b1;
    endtask

    task automatic test_udp_seq();
        apply_reset();
        arp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
            total++;
            if (udp_req !== 1'b1 || arp_req !== 1'b0 || udp_seq !== 16'(i)) begin
                bad++; $display("FAIL udp_req_%0d got req=%b seq=%0d want req=1 seq=%0d", i, udp_req, udp_seq, i);
            end
            step();
            total++;
            if (udp_req !== 1'b0) begin
                bad++; $display("FAIL udp_req_single_%0d got=%b want=0", i, udp_req);
            end
            repeat (4) step();
            total++;
            if (udp_seq !== 16'(i) || busy !== 1'b1) begin
                bad++; $display("FAIL udp_seq_stable_%0d got seq=%0d busy=%b want seq=%0d busy=1", i, udp_seq, busy, i);
            end
            udp_tx_done = 1'b1; step(); udp_tx_done = 1'b0;
            total++;
            if (busy !== 1'b0 || udp_seq !== 16'(i + 1)) begin
                bad++; $display("FAIL udp_done_%0d got seq=%0d busy=%b want seq=%0d busy=0", i, udp_seq, busy, i + 1);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        arp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
            total++;
            if (udp_req_s !== 1'b1 || udp_seq_s !== 2'(i)) begin
                bad++; $display("FAIL wrap_req_%0d got req=%b seq=%0d want req=1 seq=%0d", i, udp_req_s, udp_seq_s, i);
            end
            repeat (3) step();
            udp_tx_done = 1'b1; step(); udp_tx_done = 1'b0;
        end
        total++;
        if (udp_seq_s !== 2'd0 || busy_s !== 1'b0) begin
            bad++; $display("FAIL seq_wrap got seq=%0d busy=%b want seq=0 busy=0", udp_seq_s, busy_s);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        arp_valid = 1'b1;
        timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
        repeat (16) step();
        total++;
        if (timeout_err_s !== 1'b0 || busy_s !== 1'b1) begin
            bad++; $display("FAIL timeout_early got err=%b busy=%b want err=0 busy=1", timeout_err_s, busy_s);
        end
        step();
        total++;
        if (timeout_err_s !== 1'b1 || busy_s !== 1'b0 || udp_seq_s !== 2'd0) begin
            bad++; $display("FAIL timeout_fire got err=%b busy=%b seq=%0d want err=1 busy=0 seq=0", timeout_err_s, busy_s, udp_seq_s);
        end
        step();
        total++;
        if (timeout_err_s !== 1'b0) begin
            bad++; $display("FAIL timeout_single got=%b want=0", timeout_err_s);
        end
        timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
        repeat (16) step();
        udp_tx_done = 1'b1; step(); udp_tx_done = 1'b0;
        total++;
        if (timeout_err_s !== 1'b0 || busy_s !== 1'b0 || udp_seq_s !== 2'd1) begin
            bad++; $display("FAIL done_vs_timeout got err=%b busy=%b seq=%0d want err=0 busy=0 seq=1", timeout_err_s, busy_s, udp_seq_s);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        arp_valid = 1'b1;
        timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
        for (int i = 0; i < 300; i++) begin
            timer_pulse = 1'b1; step(); timer_pulse = 1'b0; step();
            if (i == 253) begin
                total++;
                if (drop_cnt !== 8'd254) begin
                    bad++; $display("FAIL drop_254 got=%0d want=254", drop_cnt);
                end
            end
        end
        total++;
        if (drop_cnt !== 8'd255 || busy !== 1'b1) begin
            bad++; $display("FAIL drop_saturate got cnt=%0d busy=%b want cnt=255 busy=1", drop_cnt, busy);
        end
        clr_stats = 1'b1; timer_pulse = 1'b1; step(); clr_stats = 1'b0; timer_pulse = 1'b0;
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL clr_priority got=%0d want=0", drop_cnt);
        end
        timer_pulse = 1'b1; step(); timer_pulse = 1'b0; step();
        total++;
        if (drop_cnt !== 8'd1) begin
            bad++; $display("FAIL drop_after_clr got=%0d want=1", drop_cnt);
        end
        udp_tx_done = 1'b1; step(); udp_tx_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        arp_valid = 1'b1;
        timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
        repeat (2) step();
        udp_tx_done = 1'b1; timer_pulse = 1'b1; step(); udp_tx_done = 1'b0;
        total++;
        if (busy !== 1'b0 || udp_req !== 1'b0 || drop_cnt !== 8'd1 || udp_seq !== 16'd1) begin
            bad++; $display("FAIL tick_on_done got busy=%b req=%b drop=%0d seq=%0d want 0 0 1 1", busy, udp_req, drop_cnt, udp_seq);
        end
        step(); timer_pulse = 1'b0;
        total++;
        if (udp_req !== 1'b1 || udp_seq !== 16'd1 || drop_cnt !== 8'd1) begin
            bad++; $display("FAIL tick_after_done got req=%b seq=%0d drop=%0d want 1 1 1", udp_req, udp_seq, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({arp_req, udp_req, busy, timeout_err, udp_seq, drop_cnt} !== 28'd0) begin
            bad++; $display("FAIL reset_mid got=%0h want=0", {arp_req, udp_req, busy, timeout_err, udp_seq, drop_cnt});
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_enable_off();
        enable = 1'b0; arp_valid = 1'b1;
        timer_pulse = 1'b1; step(); timer_pulse = 1'b0;
        total++;
        if ({arp_req, udp_req, busy} !== 3'b000) begin
            bad++; $display("FAIL enable_off_req got=%b want=000", {arp_req, udp_req, busy});
        end
        step();
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL enable_off_drop got=%0d want=0", drop_cnt);
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_arp();
        test_udp_seq();
        test_wrap();
        test_timeout();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_enable_off();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
